instr_encoder: RTL

// - Opposite end of the opcode decode path: takes symbolic instruction requests (opcode, func, regs, imm)
//   and packs them into 16-bit WISC-SP13 instruction words.
// - Buffers the encoded words in a small FIFO and streams them to the fetch/decode side with a valid/ready handshake.
// - Used as the self-test program source for the decode/execute pipeline, and for on-chip loading of instruction memory.

---
 rtl/instr_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs symbolic WISC-SP13 instruction requests into 16-bit words and streams them out through a small FIFO.
// Optional build macro ENC_RANGE_CHECK_EN: reject requests whose immediate does not fit the destination field.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_op,
  input  logic [1:0]         req_func,
  input  logic [2:0]         req_rs,
  input  logic [2:0]         req_rt,
  input  logic [2:0]         req_rd,
  input  logic [10:0]        req_imm,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [15:0]        instr,
  output logic [PTR_W:0]     fill_cnt,
  output logic               err,
  output logic               err_sticky,
  output logic               halted
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             halted_q, halted_d;

  logic [15:0] word_c;
  logic        illegal_c;
  logic        reject_c;
  logic        accept_c;
  logic        push_c;
  logic        pop_c;

  // Opcode-driven field packing
  always_comb begin
    word_c    = 16'h0000;
    illegal_c = 1'b0;
    case (req_op)
      5'b00000, 5'b00001: word_c = {req_op, 11'h000};
      5'b00100, 5'b00110: word_c = {req_op, req_imm};
      5'b00010, 5'b00011: illegal_c = 1'b1;
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b10000, 5'b10001, 5'b10011:
        word_c = {req_op, req_rs, req_rd, req_imm[4:0]};
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b10010, 5'b00101, 5'b00111:
        word_c = {req_op, req_rs, req_imm[7:0]};
      5'b11011, 5'b11010:
        word_c = {req_op, req_rs, req_rt, req_rd, req_func};
      5'b11100, 5'b11101, 5'b11110, 5'b11111:
        word_c = {req_op, req_rs, req_rt, req_rd, 2'b00};
      5'b11001:
        word_c = {req_op, req_rs, 3'b000, req_rd, 2'b00};
      default: word_c = 16'h0000;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_bad_c;

  // Immediate must be representable in the field it is truncated into
  always_comb begin
    range_bad_c = 1'b0;
    case (req_op)
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
        range_bad_c = (req_imm[10:5] != {6{req_imm[4]}});
      5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111:
        range_bad_c = |req_imm[10:5];
      5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111:
        range_bad_c = (req_imm[10:8] != {3{req_imm[7]}});
      5'b10010:
        range_bad_c = |req_imm[10:8];
      default: range_bad_c = 1'b0;
    endcase
  end

  assign reject_c = illegal_c | range_bad_c;
`else
  assign reject_c = illegal_c;
`endif

  assign req_ready   = (fill_cnt_q != CNT_W'(DEPTH)) && !halted_q;
  assign instr_valid = (fill_cnt_q != CNT_W'(0));
  assign instr       = mem_q[rd_ptr_q];
  assign fill_cnt    = fill_cnt_q;
  assign err         = err_q;
  assign err_sticky  = err_sticky_q;
  assign halted      = halted_q;

  assign accept_c = req_valid && req_ready;
  assign push_c   = accept_c && !reject_c;
  assign pop_c    = instr_valid && instr_ready;

  // Next-state for FIFO and status flags
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    err_d        = accept_c && reject_c;
    err_sticky_d = err_sticky_q | (accept_c && reject_c);
    halted_d     = halted_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = word_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (req_op == 5'b00000) halted_d = 1'b1;
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      fill_cnt_d = fill_cnt_q + CNT_W'(1);
    else if (!push_c && pop_c) fill_cnt_d = fill_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 16'h0000;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      halted_q     <= halted_d;
    end
  end

endmodule
